// File: rtl/uart_fifo_periph.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, runtime baud divisor, sticky error flags and level irq.
// Bus accesses acknowledge one cycle after the request; side effects commit on the request cycle.

module uart_fifo_periph_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    push,
  input  logic                    pop,
  input  logic [7:0]              wdata,
  output logic [7:0]              head_c,
  output logic [$clog2(DEPTH):0]  count_c,
  output logic                    empty_c,
  output logic                    full_c,
  output logic                    drop_c
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          push_ok_c;
  logic          pop_ok_c;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only succeeds alongside a real pop.
  always_comb begin
    count_c   = wr_ptr_q - rd_ptr_q;
    empty_c   = (count_c == '0);
    full_c    = (count_c == PW'(DEPTH));
    head_c    = mem_q[rd_ptr_q[AW-1:0]];
    pop_ok_c  = pop & ~empty_c;
    push_ok_c = push & (~full_c | pop_ok_c);
    drop_c    = push & ~push_ok_c & ~clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end
endmodule

module uart_fifo_periph #(
  parameter int unsigned CLK_HZ        = 10000000,
  parameter int unsigned UART_BIT_RATE = 115200,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned DIV_WIDTH     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);
  localparam int unsigned DIV_RST = CLK_HZ / UART_BIT_RATE;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Bus decode: a simultaneous we/re is a write.
  logic wr_c, rd_c, data_wr_c, data_rd_c, status_wr_c, div_wr_c, ctrl_wr_c;
  logic unused_wdata_c;

  assign wr_c           = sel & we;
  assign rd_c           = sel & re & ~we;
  assign data_wr_c      = wr_c & (addr == A_DATA);
  assign data_rd_c      = rd_c & (addr == A_DATA);
  assign status_wr_c    = wr_c & (addr == A_STATUS);
  assign div_wr_c       = wr_c & (addr == A_DIV);
  assign ctrl_wr_c      = wr_c & (addr == A_CTRL);
  assign unused_wdata_c = ^(wdata >> DIV_WIDTH);

  logic [DIV_WIDTH-1:0] div_q;
  logic                 txen_q, rxen_q, rxie_q, txie_q;
  logic                 rxovr_q, ferr_q, brk_q, txovf_q;

  // FIFOs
  logic [7:0]       tx_head_c, rx_head_c;
  logic [CNT_W-1:0] tx_cnt_unused, rx_cnt_c;
  logic             tx_empty_c, tx_full_c, tx_drop_c;
  logic             rx_empty_c, rx_full_c, rx_drop_c;
  logic             tx_pop_c, rx_push_c;
  logic [7:0]       rx_sh_q;

  uart_fifo_periph_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctrl_wr_c & wdata[4]),
    .push    (data_wr_c),
    .pop     (tx_pop_c),
    .wdata   (wdata[7:0]),
    .head_c  (tx_head_c),
    .count_c (tx_cnt_unused),
    .empty_c (tx_empty_c),
    .full_c  (tx_full_c),
    .drop_c  (tx_drop_c)
  );

  uart_fifo_periph_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctrl_wr_c & wdata[5]),
    .push    (rx_push_c),
    .pop     (data_rd_c),
    .wdata   (rx_sh_q),
    .head_c  (rx_head_c),
    .count_c (rx_cnt_c),
    .empty_c (rx_empty_c),
    .full_c  (rx_full_c),
    .drop_c  (rx_drop_c)
  );

  // Transmitter
  logic [1:0]           tx_state_q, tx_state_d;
  logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [7:0]           tx_sh_q, tx_sh_d;
  logic                 tx_line_d, tx_last_c, tx_go_c;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + DIV_WIDTH'(1);
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_line_d  = uart_tx;
    tx_pop_c   = 1'b0;
    tx_last_c  = (tx_cnt_q == tx_div_q - DIV_WIDTH'(1));
    tx_go_c    = txen_q & ~tx_empty_c;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
        if (tx_go_c) begin
          tx_pop_c   = 1'b1;
          tx_state_d = S_START;
          tx_div_d   = div_q;
          tx_sh_d    = tx_head_c;
          tx_line_d  = 1'b0;
        end
      end
      S_START: begin
        if (tx_last_c) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_sh_q[0];
        end
      end
      S_DATA: begin
        if (tx_last_c) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d  = tx_bit_q + 3'd1;
            tx_sh_d   = {1'b0, tx_sh_q[7:1]};
            tx_line_d = tx_sh_q[1];
          end
        end
      end
      S_STOP: begin
        if (tx_last_c) begin
          tx_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (tx_go_c) begin
            tx_pop_c   = 1'b1;
            tx_state_d = S_START;
            tx_div_d   = div_q;
            tx_sh_d    = tx_head_c;
            tx_line_d  = 1'b0;
          end else begin
            tx_state_d = S_IDLE;
            tx_line_d  = 1'b1;
          end
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_WIDTH'(DIV_RST);
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'd0;
      uart_tx    <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      uart_tx    <= tx_line_d;
    end
  end

  // Receiver: synchroniser plus a third flop for falling-edge detection.
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic [1:0]           rx_state_q, rx_state_d;
  logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [7:0]           rx_sh_d;
  logic                 rx_last_c, rx_mid_c, rx_ferr_c, rx_brk_c;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + DIV_WIDTH'(1);
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push_c  = 1'b0;
    rx_ferr_c  = 1'b0;
    rx_brk_c   = 1'b0;
    rx_last_c  = (rx_cnt_q == rx_div_q - DIV_WIDTH'(1));
    rx_mid_c   = (rx_cnt_q == (rx_div_q >> 1) - DIV_WIDTH'(1));
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rxen_q && rx_s3_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_div_d   = div_q;
        end
      end
      S_START: begin
        if (rx_mid_c) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (rx_last_c) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (rx_last_c) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          if (rx_s2_q) begin
            rx_push_c = 1'b1;
          end else begin
            rx_ferr_c = 1'b1;
            rx_brk_c  = (rx_sh_q == 8'd0);
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_WIDTH'(DIV_RST);
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'd0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  // Register read mux
  logic [31:0] status_c, rd_mux_c, rx_cnt_w_c;
  logic [3:0]  rx_cnt_sat_c;

  always_comb begin
    rx_cnt_w_c   = 32'(rx_cnt_c);
    rx_cnt_sat_c = (rx_cnt_w_c > 32'd15) ? 4'hF : rx_cnt_w_c[3:0];
    status_c        = '0;
    status_c[0]     = ~rx_empty_c;
    status_c[1]     = rx_full_c;
    status_c[2]     = tx_empty_c;
    status_c[3]     = tx_full_c;
    status_c[4]     = (tx_state_q != S_IDLE);
    status_c[5]     = rxovr_q;
    status_c[6]     = ferr_q;
    status_c[7]     = brk_q;
    status_c[8]     = txovf_q;
    status_c[15:12] = rx_cnt_sat_c;
    case (addr)
      A_DATA:   rd_mux_c = rx_empty_c ? 32'd0 : {23'd0, 1'b1, rx_head_c};
      A_STATUS: rd_mux_c = status_c;
      A_DIV:    rd_mux_c = 32'(div_q);
      default:  rd_mux_c = {28'd0, txie_q, rxie_q, rxen_q, txen_q};
    endcase
  end

  // Bus response, control registers, sticky flags and interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready   <= 1'b0;
      rdata   <= '0;
      div_q   <= DIV_WIDTH'(DIV_RST);
      txen_q  <= 1'b1;
      rxen_q  <= 1'b1;
      rxie_q  <= 1'b0;
      txie_q  <= 1'b0;
      rxovr_q <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
      txovf_q <= 1'b0;
      irq     <= 1'b0;
    end else begin
      ready <= sel & (we | re);
      rdata <= rd_c ? rd_mux_c : 32'd0;
      if (div_wr_c) begin
        div_q <= (wdata[DIV_WIDTH-1:0] < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : wdata[DIV_WIDTH-1:0];
      end
      if (ctrl_wr_c) begin
        {txie_q, rxie_q, rxen_q, txen_q} <= wdata[3:0];
      end
      // A new event in the same cycle as a clear keeps the flag set.
      rxovr_q <= (rxovr_q & ~(status_wr_c & wdata[5])) | rx_drop_c;
      ferr_q  <= (ferr_q  & ~(status_wr_c & wdata[6])) | rx_ferr_c;
      brk_q   <= (brk_q   & ~(status_wr_c & wdata[7])) | rx_brk_c;
      txovf_q <= (txovf_q & ~(status_wr_c & wdata[8])) | tx_drop_c;
      irq     <= (rxie_q & ~rx_empty_c) | (txie_q & tx_empty_c & (tx_state_q == S_IDLE));
    end
  end
endmodule
